binned_mask_centroid: RTL
=========================

Name: binned_mask_centroid

Overview:
- Downstream consumer of the 4x4 binned 1-bit mask stream from `binning_2`.
- Per frame, accumulates mask area, coordinate sums and bounding box over the binned grid.
- At frame end, snapshots the accumulators and computes the floor centroid with two sequential dividers.
- Publishes one result per frame to the tracking/overlay logic while the next frame keeps accumulating.

Parameters:
- HRES, 320, binned frame width (input hcount range 0..HRES-1).
- VRES, 180, binned frame height (input vcount range 0..VRES-1).
- Derived, not overridable: HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES), AREA_W=$clog2(HRES*VRES+1), SUM_W=$clog2(HRES*VRES*(HRES>VRES?HRES:VRES)).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- hcount_in  input  HWIDTH  binned column of incoming pixel.
- vcount_in  input  VWIDTH  binned row of incoming pixel.
- pixel_data_in  input  1  binned mask bit.
- data_valid_in  input  1  qualifies the three inputs above.
- centroid_x_out  output  HWIDTH  floor(sum_x/area).
- centroid_y_out  output  VWIDTH  floor(sum_y/area).
- area_out  output  AREA_W  count of set pixels in the frame.
- bbox_out  output  2*HWIDTH+2*VWIDTH  {x_min,x_max,y_min,y_max}.
- found_out  output  1  area_out != 0.
- result_valid_out  output  1  one-cycle pulse; all result outputs are updated on the same cycle.
- busy_out  output  1  high while DIVIDE state is active.
- overrun_out  output  1  one-cycle pulse when a frame result is dropped.

Behaviour:
- Reset: every output 0; accumulators cleared; x_min=HRES-1, y_min=VRES-1, x_max=y_max=0; state IDLE_ACC.
- Accumulation: on data_valid_in && pixel_data_in with hcount_in<HRES and vcount_in<VRES:
  - area += 1; sum_x += hcount; sum_y += vcount.
  - Update min/max.
  - Pixels with data_valid_in low or out-of-range coordinates are ignored.
- Frame end: a valid beat (any pixel value) at hcount=HRES-1, vcount=VRES-1, sampled at cycle T.
  - That beat's pixel is included in the frame.
  - At T+1: accumulators are snapshotted into divider operands and cleared to reset values in the same cycle.
  - A valid pixel arriving at T+1 belongs to the new frame.
- FSM IDLE_ACC -> DIVIDE on frame end if snapshot area != 0.
  - DIVIDE runs two restoring dividers in parallel for exactly SUM_W iterations, one quotient bit per cycle.
  - DIVIDE -> IDLE_ACC on completion; result_valid_out pulses at T+SUM_W+2.
- Zero-area frame: no divide; result_valid_out pulses at T+2 with found_out=0.
  - Centroid outputs 0; bbox_out reports the reset values.
- Quotients are truncated to HWIDTH/VWIDTH bits; the math guarantees they fit. Division rounds by floor.
- Outputs hold their last values between pulses.
- Frame end while busy_out=1: that frame's result is discarded, overrun_out pulses at T+1, accumulators are still cleared, and the in-flight divide is unaffected.
- Accumulation is never stalled by DIVIDE; there is no backpressure.
- Reset mid-DIVIDE: abort; no result_valid_out; outputs 0 on the next cycle.
- SUM_W must hold HRES*VRES*max(HRES,VRES)-1 without overflow; the bench asserts no wrap.

Decomposition:
- Package binning_pkg:
  - Default binned HRES/VRES constants.
  - Width functions for AREA_W/SUM_W.
  - Typedef bbox_t {x_min,x_max,y_min,y_max}.
  - FSM state enum {IDLE_ACC, DIVIDE}.
- Sub-module seq_divider: parameterised restoring unsigned divider.
  - Interface: start/dividend/divisor in; quotient/done out.
  - Fixed WIDTH-cycle latency; instantiated twice, once each for x and y.

Test Plan (HRES=320, VRES=180, so SUM_W=25, latency 27):
- Single set pixel at (10,20), frame end at T -> pulse at T+27: x=10, y=20, area=1, bbox {10,10,20,20}, found=1.
- All-zero frame -> pulse at T+2: area=0, found=0, x=y=0, bbox {319,0,179,0}.
- 2x2 block at cols 100..101, rows 50..51, with random data_valid_in gaps -> area=4, x=100 (402/4), y=50 (202/4), bbox {100,101,50,51}.
- All-ones frame -> area=57600, x=159, y=89, bbox {0,319,0,179}, no accumulator overflow.
- Back-to-back frames: second frame's pixel at (5,5) arrives during DIVIDE -> first result unchanged; second result x=5, y=5, area=1.
- Reset asserted at T+10 during DIVIDE -> no pulse, all outputs 0.
- Forced short frame ending while busy -> overrun_out pulse and that frame's result is dropped.

Source files
------------

// File: rtl/binning_pkg.sv
// rtl/binning_pkg.sv - shared constants, width helpers and types for the binned mask centroid
package binning_pkg;

  localparam int DEF_HRES = 320;
  localparam int DEF_VRES = 180;
  localparam int DEF_HW   = $clog2(DEF_HRES);
  localparam int DEF_VW   = $clog2(DEF_VRES);

  // Bits needed to count every pixel of an h x v frame, including the full count.
  function automatic int area_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  // Bits needed for a coordinate sum over a full frame (also the divider width).
  function automatic int sum_w(input int h, input int v);
    int m;
    m = (h > v) ? h : v;
    return $clog2(h * v * m);
  endfunction

  typedef struct packed {
    logic [DEF_HW-1:0] x_min;
    logic [DEF_HW-1:0] x_max;
    logic [DEF_VW-1:0] y_min;
    logic [DEF_VW-1:0] y_max;
  } bbox_t;

  typedef enum logic {
    IDLE_ACC,
    DIVIDE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per cycle
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   start              load dividend/divisor and begin (ignored until previous run is irrelevant)
//   dividend, divisor  WIDTH-bit unsigned operands, sampled on start
//   quotient           low QWIDTH bits of the quotient, valid while done is high and after
//   done               one-cycle pulse exactly WIDTH cycles after start
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter int QWIDTH = WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic [WIDTH-1:0]  dividend,
  input  logic [WIDTH-1:0]  divisor,
  output logic [QWIDTH-1:0] quotient,
  output logic              done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_shift;
  logic             sub_ok;

  // quo doubles as the dividend shift register: its MSB feeds the partial
  // remainder while quotient bits enter at the LSB.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign sub_ok    = (rem_shift >= {1'b0, dvs});
  assign quotient  = quo[QWIDTH-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem <= '0;
        quo <= dividend;
        dvs <= divisor;
        cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
        // When subtracting, the true difference is below dvs, so WIDTH-bit
        // wraparound arithmetic yields the exact remainder.
        rem <= sub_ok ? (rem_shift[WIDTH-1:0] - dvs) : rem_shift[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], sub_ok};
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/binned_mask_centroid.sv
// rtl/binned_mask_centroid.sv - per-frame area, bounding box and floor centroid of a binned mask
// Ports:
//   clk_in, rst_in                 clock, synchronous active-high reset
//   hcount_in, vcount_in           binned pixel coordinate
//   pixel_data_in, data_valid_in   mask bit and its qualifier
//   centroid_x_out/centroid_y_out  floor(sum/area) of the last published frame
//   area_out, bbox_out, found_out  set-pixel count, {x_min,x_max,y_min,y_max}, area != 0
//   result_valid_out               one-cycle pulse when the result outputs update
//   busy_out                       high while the dividers run
//   overrun_out                    one-cycle pulse when a frame result is dropped
module binned_mask_centroid
  import binning_pkg::*;
#(
  parameter  int HRES   = DEF_HRES,
  parameter  int VRES   = DEF_VRES,
  localparam int HWIDTH = $clog2(HRES),
  localparam int VWIDTH = $clog2(VRES),
  localparam int AREA_W = area_w(HRES, VRES),
  localparam int SUM_W  = sum_w(HRES, VRES)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [HWIDTH-1:0]            hcount_in,
  input  logic [VWIDTH-1:0]            vcount_in,
  input  logic                         pixel_data_in,
  input  logic                         data_valid_in,
  output logic [HWIDTH-1:0]            centroid_x_out,
  output logic [VWIDTH-1:0]            centroid_y_out,
  output logic [AREA_W-1:0]            area_out,
  output logic [2*HWIDTH+2*VWIDTH-1:0] bbox_out,
  output logic                         found_out,
  output logic                         result_valid_out,
  output logic                         busy_out,
  output logic                         overrun_out
);

  localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HRES - 1);
  localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VRES - 1);
  localparam bbox_t BBOX_RESET = '{x_min: H_LAST, x_max: '0, y_min: V_LAST, y_max: '0};

  state_t            state;
  logic              frame_end, frame_end_q, zero_pend, pix_hit;
  logic [AREA_W-1:0] area_acc, area_nxt, snap_area;
  logic [SUM_W-1:0]  sx_acc, sx_nxt, sy_acc, sy_nxt;
  bbox_t             bb_acc, bb_nxt, snap_bbox;
  logic              div_start, done_x, done_y;
  logic [HWIDTH-1:0] qx;
  logic [VWIDTH-1:0] qy;

  assign busy_out  = (state == DIVIDE);
  assign div_start = (state == IDLE_ACC) && frame_end_q && (area_acc != '0);

  // The cycle after a frame end, the accumulators restart from reset values
  // while still absorbing that cycle's pixel into the new frame.
  always_comb begin
    pix_hit   = data_valid_in && pixel_data_in && (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
    frame_end = data_valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    area_nxt  = frame_end_q ? '0 : area_acc;
    sx_nxt    = frame_end_q ? '0 : sx_acc;
    sy_nxt    = frame_end_q ? '0 : sy_acc;
    bb_nxt    = frame_end_q ? BBOX_RESET : bb_acc;
    if (pix_hit) begin
      area_nxt = area_nxt + AREA_W'(1);
      sx_nxt   = sx_nxt + SUM_W'(hcount_in);
      sy_nxt   = sy_nxt + SUM_W'(vcount_in);
      if (hcount_in < bb_nxt.x_min) bb_nxt.x_min = hcount_in;
      if (hcount_in > bb_nxt.x_max) bb_nxt.x_max = hcount_in;
      if (vcount_in < bb_nxt.y_min) bb_nxt.y_min = vcount_in;
      if (vcount_in > bb_nxt.y_max) bb_nxt.y_max = vcount_in;
    end
  end

  // Dividers read the live accumulators on start; they are cleared on the
  // same edge, so the operands are captured inside the dividers.
  seq_divider #(.WIDTH(SUM_W), .QWIDTH(HWIDTH)) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (sx_acc),
    .divisor  (SUM_W'(area_acc)),
    .quotient (qx),
    .done     (done_x)
  );

  seq_divider #(.WIDTH(SUM_W), .QWIDTH(VWIDTH)) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (sy_acc),
    .divisor  (SUM_W'(area_acc)),
    .quotient (qy),
    .done     (done_y)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE_ACC;
      frame_end_q      <= 1'b0;
      zero_pend        <= 1'b0;
      area_acc         <= '0;
      sx_acc           <= '0;
      sy_acc           <= '0;
      bb_acc           <= BBOX_RESET;
      snap_area        <= '0;
      snap_bbox        <= BBOX_RESET;
      centroid_x_out   <= '0;
      centroid_y_out   <= '0;
      area_out         <= '0;
      bbox_out         <= '0;
      found_out        <= 1'b0;
      result_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
    end else begin
      frame_end_q      <= frame_end;
      area_acc         <= area_nxt;
      sx_acc           <= sx_nxt;
      sy_acc           <= sy_nxt;
      bb_acc           <= bb_nxt;
      result_valid_out <= 1'b0;
      overrun_out      <= 1'b0;
      zero_pend        <= 1'b0;

      // Empty frame: publish one cycle after the snapshot, no divide needed.
      if (zero_pend) begin
        centroid_x_out   <= '0;
        centroid_y_out   <= '0;
        area_out         <= '0;
        bbox_out         <= BBOX_RESET;
        found_out        <= 1'b0;
        result_valid_out <= 1'b1;
      end

      case (state)
        IDLE_ACC: begin
          if (frame_end_q) begin
            if (area_acc != '0) begin
              state     <= DIVIDE;
              snap_area <= area_acc;
              snap_bbox <= bb_acc;
            end else begin
              zero_pend <= 1'b1;
            end
          end
        end
        DIVIDE: begin
          if (frame_end_q) begin
            overrun_out <= 1'b1;
          end
          if (done_x && done_y) begin
            state            <= IDLE_ACC;
            centroid_x_out   <= qx;
            centroid_y_out   <= qy;
            area_out         <= snap_area;
            bbox_out         <= snap_bbox;
            found_out        <= 1'b1;
            result_valid_out <= 1'b1;
          end
        end
        default: state <= IDLE_ACC;
      endcase
    end
  end

endmodule
